xbar_pipe: RTL and testbench
============================

// Module: xbar_pipe
// PURPOSE
//  Parametrised N-port crossbar for the bufferless (BLESS) router datapath: maps ranked channels to output ports per allocPV.
//  Sits between port allocator and output link registers; adds valid tracking, one output pipeline stage,
//  multi-claim conflict detection and per-output traversal counters.
// PARAMETERS
//  NUM_PORT   4   number of input and output ports; also number of ranked channels
//  DATA_W     64  flit width (DATA_WIDTH_XBAR in global.vh)
//  IDX_W      2   clog2(NUM_PORT); width of rank/select indices
//  REG_OUT    1   1: outputs registered (latency 1); 0: combinational data/valid/apv (latency 0)
//  CNT_W      16  width of per-output flit counters
// PORTS
//  clk          in   1              clock
//  reset        in   1              asynchronous, active-high reset
//  in_data      in   NUM_PORT*DATA_W flits, slice p = input port p
//  in_valid     in   NUM_PORT       flit present on input port p
//  indir_rank   in   NUM_PORT*IDX_W  slice k = input port carried by ranked channel k (rank 0 = highest priority)
//  alloc_pv     in   NUM_PORT*NUM_PORT slice k = one-hot output vector granted to channel k
//  cnt_clr      in   1              synchronous clear of all counters and err_sticky
//  out_data     out  NUM_PORT*DATA_W flit on output port j
//  out_valid    out  NUM_PORT       output j carries a valid flit
//  apv_on_out   out  NUM_PORT*NUM_PORT APV of the channel driving output j (0 if none)
//  out_src      out  NUM_PORT*IDX_W  input port driving output j (0 if none)
//  conflict     out  NUM_PORT       output j claimed by >1 channel this cycle (aligned with out_*)
//  err_sticky   out  1              set on any conflict; held until cnt_clr or reset
//  flit_cnt     out  NUM_PORT*CNT_W  flits delivered per output, saturating
// BEHAVIOUR
//  Select: for output j, winner = lowest k with alloc_pv[k][j]=1 and in_valid[indir_rank[k]]=1; channels whose source is invalid are ignored.
//  No winner: out_valid[j]=0, out_data[j]=0, apv_on_out[j]=0, out_src[j]=0.
//  Winner: out_data[j]=in_data[indir_rank[k]], apv_on_out[j]=alloc_pv[k], out_src[j]=indir_rank[k].
//  Conflict: >=2 qualifying channels on output j -> conflict[j]=1; lowest k still wins; others dropped (allocator bug indicator).
//  A channel with multi-hot APV drives every output it claims (multicast allowed, no error).
//  REG_OUT=1: all out_*, conflict registered on clk; latency 1, new result every cycle, no stall.
//  REG_OUT=0: out_data/out_valid/apv_on_out/out_src/conflict combinational; counters still registered.
//  Counters: flit_cnt[j] += 1 on each cycle out_valid[j] is asserted (registered view), saturate at 2^CNT_W-1, no wrap.
//  err_sticky set the cycle after a conflict is visible at outputs.
//  cnt_clr: clears counters and err_sticky next edge; a simultaneous increment is lost (clear wins); err set in same cycle is lost too.
//  Reset (async, any time): all registered outputs, counters, err_sticky -> 0 immediately; flit in flight discarded.
//  First edge after reset deassertion captures current inputs normally.
//  IDX_W must equal clog2(NUM_PORT); indir_rank >= NUM_PORT is out of range -> treated as invalid source.
// STRUCTURE
//  global.vh: NUM_PORT, DATA_WIDTH_XBAR, PC_INDEX_WIDTH, NULL_PC defaults shared with router.
//  Sub-module xbar_out_sel (one per output): priority pick over channels -> winner index, hit, conflict.
//  Top: generate loop over outputs, data mux, optional pipeline register, counters, sticky flag.
// TESTING
//  Reset mid-traffic: reset=1 with valid claims -> all out_*/flit_cnt/err_sticky = 0 same cycle.
//  Permutation: rank={3,2,1,0}, apv ch0..3=0001,0010,0100,1000, all valid -> out0=in3,out1=in2,out2=in1,out3=in0 after 1 clk.
//  Conflict: apv ch0=ch2=0100, rank0=1,rank2=3 -> out2=in1, conflict[2]=1, err_sticky=1 next clk, cnt2 +1.
//  Invalid source: ch0 claims out1 with in_valid[rank0]=0, ch1 claims out1 valid -> out1 from ch1, conflict=0.
//  Saturation: CNT_W=4, 20 cycles valid on out0 -> flit_cnt0=15; cnt_clr with valid -> 0.
//  REG_OUT=0 build: same permutation -> outputs equal same cycle; counters lag 1 clk.

Source files
------------

// File: rtl/xbar_pipe_pkg.sv
// Shared defaults for the bufferless router crossbar datapath.
package xbar_pipe_pkg;
   localparam int NUM_PORT_DEF = 4;
   localparam int DATA_W_DEF   = 64;
   localparam int IDX_W_DEF    = 2;
   localparam int CNT_W_DEF    = 16;
endpackage

// File: rtl/xbar_pipe_if.sv
// Crossbar bus: allocator-side inputs and output-link-side results.
interface xbar_pipe_if #(
   parameter int NUM_PORT = 4,
   parameter int DATA_W   = 64,
   parameter int IDX_W    = 2,
   parameter int CNT_W    = 16
);
   logic [NUM_PORT*DATA_W-1:0]   in_data;
   logic [NUM_PORT-1:0]          in_valid;
   logic [NUM_PORT*IDX_W-1:0]    indir_rank;
   logic [NUM_PORT*NUM_PORT-1:0] alloc_pv;
   logic                         cnt_clr;
   logic [NUM_PORT*DATA_W-1:0]   out_data;
   logic [NUM_PORT-1:0]          out_valid;
   logic [NUM_PORT*NUM_PORT-1:0] apv_on_out;
   logic [NUM_PORT*IDX_W-1:0]    out_src;
   logic [NUM_PORT-1:0]          conflict;
   logic                         err_sticky;
   logic [NUM_PORT*CNT_W-1:0]    flit_cnt;

   modport master (
      output in_data, in_valid, indir_rank, alloc_pv, cnt_clr,
      input  out_data, out_valid, apv_on_out, out_src, conflict, err_sticky, flit_cnt
   );
   modport slave (
      input  in_data, in_valid, indir_rank, alloc_pv, cnt_clr,
      output out_data, out_valid, apv_on_out, out_src, conflict, err_sticky, flit_cnt
   );
endinterface

// File: rtl/xbar_pipe_out_sel.sv
// Per-output priority pick: lowest claiming channel wins; flags multiple claims.
module xbar_out_sel #(
   parameter int NUM_PORT = 4,
   parameter int IDX_W    = 2
) (
   input  logic [NUM_PORT-1:0] claim,
   output logic [IDX_W-1:0]    win,
   output logic                hit,
   output logic                multi
);
   always_comb begin
      win   = '0;
      hit   = 1'b0;
      multi = 1'b0;
      for (int k = 0; k < NUM_PORT; k++) begin
         if (claim[k]) begin
            if (hit) begin
               multi = 1'b1;
            end else begin
               win = IDX_W'(k);
               hit = 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/xbar_pipe.sv
// N-port crossbar: ranked channels to outputs per allocPV, optional output
// register, conflict detection, sticky error and saturating per-output counters.
module xbar_pipe
   import xbar_pipe_pkg::*;
#(
   parameter int NUM_PORT = NUM_PORT_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int IDX_W    = IDX_W_DEF,
   parameter int REG_OUT  = 1,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic        clk,
   input  logic        reset,
   xbar_pipe_if.slave  bus
);
   logic [IDX_W-1:0]    rank_arr [NUM_PORT];
   logic [NUM_PORT-1:0] apv_arr  [NUM_PORT];
   logic [DATA_W-1:0]   in_arr   [NUM_PORT];
   logic [NUM_PORT-1:0] src_ok;
   logic [NUM_PORT-1:0] claim    [NUM_PORT];
   logic [IDX_W-1:0]    win      [NUM_PORT];
   logic                hit      [NUM_PORT];
   logic                multi    [NUM_PORT];

   logic [DATA_W-1:0]   data_p0  [NUM_PORT];
   logic [NUM_PORT-1:0] apv_p0   [NUM_PORT];
   logic [IDX_W-1:0]    src_p0   [NUM_PORT];
   logic [NUM_PORT-1:0] vld_p0;
   logic [NUM_PORT-1:0] conf_p0;
   logic [DATA_W-1:0]   data_p1  [NUM_PORT];
   logic [NUM_PORT-1:0] apv_p1   [NUM_PORT];
   logic [IDX_W-1:0]    src_p1   [NUM_PORT];
   logic [NUM_PORT-1:0] vld_p1;
   logic [NUM_PORT-1:0] conf_p1;

   logic [CNT_W-1:0]    cnt      [NUM_PORT];
   logic                err;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   for (genvar p = 0; p < NUM_PORT; p++) begin : g_unpack
      assign rank_arr[p] = bus.indir_rank[p*IDX_W +: IDX_W];
      assign apv_arr[p]  = bus.alloc_pv[p*NUM_PORT +: NUM_PORT];
      assign in_arr[p]   = bus.in_data[p*DATA_W +: DATA_W];
   end

   // A rank index that matches no port leaves the channel unqualified.
   always_comb begin
      src_ok = '0;
      for (int k = 0; k < NUM_PORT; k++) begin
         for (int p = 0; p < NUM_PORT; p++) begin
            if (rank_arr[k] == IDX_W'(p)) src_ok[k] = bus.in_valid[p];
         end
      end
   end

   // p0: per-output selection and data mux
   for (genvar j = 0; j < NUM_PORT; j++) begin : g_out
      always_comb begin
         for (int k = 0; k < NUM_PORT; k++) claim[j][k] = apv_arr[k][j] & src_ok[k];
      end

      xbar_out_sel #(.NUM_PORT(NUM_PORT), .IDX_W(IDX_W)) u_sel (
         .claim (claim[j]),
         .win   (win[j]),
         .hit   (hit[j]),
         .multi (multi[j])
      );

      always_comb begin
         data_p0[j] = '0;
         apv_p0[j]  = '0;
         src_p0[j]  = '0;
         if (hit[j]) begin
            src_p0[j]  = rank_arr[win[j]];
            apv_p0[j]  = apv_arr[win[j]];
            data_p0[j] = in_arr[rank_arr[win[j]]];
         end
      end

      assign bus.out_data[j*DATA_W +: DATA_W]       = data_p1[j];
      assign bus.apv_on_out[j*NUM_PORT +: NUM_PORT] = apv_p1[j];
      assign bus.out_src[j*IDX_W +: IDX_W]          = src_p1[j];
      assign bus.flit_cnt[j*CNT_W +: CNT_W]         = cnt[j];
   end

   always_comb begin
      vld_p0  = '0;
      conf_p0 = '0;
      for (int j = 0; j < NUM_PORT; j++) begin
         vld_p0[j]  = hit[j];
         conf_p0[j] = multi[j];
      end
   end

   // p1: optional output register
   if (REG_OUT != 0) begin : g_reg
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int j = 0; j < NUM_PORT; j++) begin
               data_p1[j] <= '0;
               apv_p1[j]  <= '0;
               src_p1[j]  <= '0;
            end
            vld_p1  <= '0;
            conf_p1 <= '0;
         end else begin
            data_p1 <= data_p0;
            apv_p1  <= apv_p0;
            src_p1  <= src_p0;
            vld_p1  <= vld_p0;
            conf_p1 <= conf_p0;
         end
      end
   end else begin : g_comb
      assign data_p1 = data_p0;
      assign apv_p1  = apv_p0;
      assign src_p1  = src_p0;
      assign vld_p1  = vld_p0;
      assign conf_p1 = conf_p0;
   end

   // Counters and sticky flag observe the visible outputs; clear beats update.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int j = 0; j < NUM_PORT; j++) cnt[j] <= '0;
         err <= 1'b0;
      end else if (bus.cnt_clr) begin
         for (int j = 0; j < NUM_PORT; j++) cnt[j] <= '0;
         err <= 1'b0;
      end else begin
         for (int j = 0; j < NUM_PORT; j++) begin
            if (vld_p1[j]) cnt[j] <= sat_inc(cnt[j]);
         end
         if (|conf_p1) err <= 1'b1;
      end
   end

   assign bus.out_valid  = vld_p1;
   assign bus.conflict   = conf_p1;
   assign bus.err_sticky = err;
endmodule

// File: tb/tb_xbar_pipe.sv
// Bench for xbar_pipe: a registered build (CNT_W=16) and a combinational build
// (CNT_W=4) driven with the same vectors and checked against a behavioural model.
module tb_xbar_pipe;
   localparam int NP = 4;
   localparam int DW = 64;
   localparam int IW = 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [NP*DW-1:0] in_data = '0;
   logic [NP-1:0]    in_valid = '0;
   logic [NP*IW-1:0] rank = '0;
   logic [NP*NP-1:0] apv = '0;
   logic             cnt_clr = 1'b0;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   xbar_pipe_if #(.NUM_PORT(NP), .DATA_W(DW), .IDX_W(IW), .CNT_W(16)) ia ();
   xbar_pipe_if #(.NUM_PORT(NP), .DATA_W(DW), .IDX_W(IW), .CNT_W(4))  ib ();

   assign ia.in_data = in_data;  assign ib.in_data = in_data;
   assign ia.in_valid = in_valid; assign ib.in_valid = in_valid;
   assign ia.indir_rank = rank;  assign ib.indir_rank = rank;
   assign ia.alloc_pv = apv;     assign ib.alloc_pv = apv;
   assign ia.cnt_clr = cnt_clr;  assign ib.cnt_clr = cnt_clr;

   xbar_pipe #(.NUM_PORT(NP), .DATA_W(DW), .IDX_W(IW), .REG_OUT(1), .CNT_W(16)) dut_a (
      .clk(clk), .reset(reset), .bus(ia));
   xbar_pipe #(.NUM_PORT(NP), .DATA_W(DW), .IDX_W(IW), .REG_OUT(0), .CNT_W(4)) dut_b (
      .clk(clk), .reset(reset), .bus(ib));

   typedef struct packed {
      logic [255:0] d;
      logic [3:0]   v;
      logic [15:0]  ap;
      logic [7:0]   s;
      logic [3:0]   c;
   } res_t;

   // What every output must show for the present inputs.
   function automatic res_t model_now(input logic [255:0] di, input logic [3:0] vi,
                                      input logic [7:0] ri, input logic [15:0] ai);
      res_t r;
      r = '0;
      for (int j = 0; j < NP; j++) begin
         for (int k = 0; k < NP; k++) begin
            int src;
            src = int'(ri[k*IW +: IW]);
            if (ai[k*NP + j] && src < NP && vi[src]) begin
               if (r.v[j]) r.c[j] = 1'b1;
               else begin
                  r.v[j] = 1'b1;
                  r.d[j*DW +: DW] = di[src*DW +: DW];
                  r.ap[j*NP +: NP] = ai[k*NP +: NP];
                  r.s[j*IW +: IW] = ri[k*IW +: IW];
               end
            end
         end
      end
      return r;
   endfunction

   res_t now_r;
   always_comb now_r = model_now(in_data, in_valid, rank, apv);

   res_t ea = '0;
   int cnt_a [NP] = '{0, 0, 0, 0};
   int cnt_b [NP] = '{0, 0, 0, 0};
   bit err_a = 1'b0;
   bit err_b = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         ea <= '0;
         for (int j = 0; j < NP; j++) begin
            cnt_a[j] <= 0;
            cnt_b[j] <= 0;
         end
         err_a <= 1'b0;
         err_b <= 1'b0;
      end else begin
         for (int j = 0; j < NP; j++) begin
            cnt_a[j] <= cnt_clr ? 0 : ((ea.v[j] && cnt_a[j] < 65535) ? cnt_a[j] + 1 : cnt_a[j]);
            cnt_b[j] <= cnt_clr ? 0 : ((now_r.v[j] && cnt_b[j] < 15) ? cnt_b[j] + 1 : cnt_b[j]);
         end
         err_a <= cnt_clr ? 1'b0 : (err_a | (|ea.c));
         err_b <= cnt_clr ? 1'b0 : (err_b | (|now_r.c));
         ea <= now_r;
      end
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      chk("a_data", ia.out_data, ea.d);
      chk("a_valid", ia.out_valid, ea.v);
      chk("a_apv", ia.apv_on_out, ea.ap);
      chk("a_src", ia.out_src, ea.s);
      chk("a_conf", ia.conflict, ea.c);
      chk("a_err", ia.err_sticky, err_a);
      chk("a_cnt", ia.flit_cnt, {16'(cnt_a[3]), 16'(cnt_a[2]), 16'(cnt_a[1]), 16'(cnt_a[0])});
      chk("b_data", ib.out_data, now_r.d);
      chk("b_valid", ib.out_valid, now_r.v);
      chk("b_apv", ib.apv_on_out, now_r.ap);
      chk("b_src", ib.out_src, now_r.s);
      chk("b_conf", ib.conflict, now_r.c);
      chk("b_err", ib.err_sticky, err_b);
      chk("b_cnt", ib.flit_cnt, {4'(cnt_b[3]), 4'(cnt_b[2]), 4'(cnt_b[1]), 4'(cnt_b[0])});
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] r, input logic [15:0] a, input logic [3:0] v);
      rank = r;
      apv = a;
      in_valid = v;
   endtask

   initial begin
      for (int p = 0; p < NP; p++) in_data[p*DW +: DW] = 64'h0123_4567_89AB_CD00 + 64'(p);
      #2 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_a_valid", ia.out_valid, 4'h0);
      chk("rst_a_cnt", ia.flit_cnt, 64'h0);
      chk("rst_b_cnt", ib.flit_cnt, 16'h0);
      reset = 1'b0;
      step();

      // permutation
      drive(8'h1B, 16'h8421, 4'hF);
      #1;
      chk("perm_b_out0", ib.out_data[63:0], 64'h0123_4567_89AB_CD03);
      chk("perm_b_src", ib.out_src, 8'h1B);
      chk("perm_b_cnt_lag", ib.flit_cnt, 16'h0000);
      step();
      chk("perm_a_out0", ia.out_data[63:0], 64'h0123_4567_89AB_CD03);
      chk("perm_a_out3", ia.out_data[255:192], 64'h0123_4567_89AB_CD00);
      chk("perm_a_valid", ia.out_valid, 4'hF);
      chk("perm_a_apv", ia.apv_on_out, 16'h8421);
      chk("perm_a_cnt_lag", ia.flit_cnt, 64'h0);
      chk("perm_b_cnt", ib.flit_cnt, 16'h1111);
      step();
      chk("perm_a_cnt", ia.flit_cnt, 64'h0001_0001_0001_0001);

      // clear, then two channels claim output 2
      drive(8'h00, 16'h0000, 4'h0);
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      drive(8'h31, 16'h0404, 4'hF);
      step();
      chk("conf_a_out2", ia.out_data[191:128], 64'h0123_4567_89AB_CD01);
      chk("conf_a_flag", ia.conflict, 4'b0100);
      chk("conf_a_src", ia.out_src, 8'h10);
      chk("conf_a_err_early", ia.err_sticky, 1'b0);
      drive(8'h00, 16'h0000, 4'h0);
      step();
      chk("conf_a_err", ia.err_sticky, 1'b1);
      chk("conf_a_cnt", ia.flit_cnt, 64'h0000_0001_0000_0000);

      // invalid source on the higher-priority channel
      drive(8'h08, 16'h0022, 4'b0100);
      #1;
      chk("inv_b_valid", ib.out_valid, 4'b0010);
      chk("inv_b_conf", ib.conflict, 4'b0000);
      chk("inv_b_out1", ib.out_data[127:64], 64'h0123_4567_89AB_CD02);
      chk("inv_b_apv", ib.apv_on_out, 16'h0020);
      step();

      // multicast: one channel on every output
      drive(8'h02, 16'h000F, 4'b0100);
      #1;
      chk("mc_b_src", ib.out_src, 8'hAA);
      chk("mc_b_apv", ib.apv_on_out, 16'hFFFF);
      chk("mc_b_conf", ib.conflict, 4'b0000);
      chk("mc_b_out3", ib.out_data[255:192], 64'h0123_4567_89AB_CD02);
      step();

      // saturation of the 4-bit counter, then clear with traffic present
      drive(8'h00, 16'h0001, 4'b0001);
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      repeat (20) step();
      chk("sat_b_cnt0", ib.flit_cnt[3:0], 4'd15);
      cnt_clr = 1'b1;
      step();
      chk("clr_b_cnt0", ib.flit_cnt[3:0], 4'd0);
      cnt_clr = 1'b0;

      // asynchronous reset in the middle of a cycle with traffic running
      repeat (3) step();
      #2 reset = 1'b1;
      #1;
      chk("mrst_a_valid", ia.out_valid, 4'h0);
      chk("mrst_a_data", ia.out_data, 256'h0);
      chk("mrst_a_cnt", ia.flit_cnt, 64'h0);
      chk("mrst_a_err", ia.err_sticky, 1'b0);
      chk("mrst_b_cnt", ib.flit_cnt, 16'h0);
      step();
      reset = 1'b0;
      step();
      chk("post_rst_a_valid", ia.out_valid, 4'b0001);
      drive(8'h00, 16'h0000, 4'h0);
      repeat (3) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
